// File: rtl/led_pkg.sv
// Shared types and default sizing for the breathing user-LED stage.
package led_pkg;

    localparam int LED_PWM_BITS_DEF = 8;
    localparam int LED_STEP_DIV_DEF = 15686;

    typedef enum logic [1:0] {
        HOLD_LO = 2'd0,
        RISE    = 2'd1,
        HOLD_HI = 2'd2,
        FALL    = 2'd3
    } breath_state_t;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM generator; the duty is latched only at the period boundary.
// pwm_out is the raw compare result, registered by the caller.
module led_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE = 1;

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_MAX) begin
                duty_q <= duty;
            end
        end
    end

    // A full-scale duty would otherwise leave one dark cycle per period.
    always_comb begin
        pwm_out = 1'b0;
        if (duty_q == CNT_MAX) begin
            pwm_out = 1'b1;
        end else begin
            pwm_out = (cnt_q < duty_q);
        end
    end

endmodule

// File: rtl/led_breather.sv
// Breathing LED driver: ramps PWM brightness up/down following blink_in edges.
// Optional gamma-2 duty mapping is enabled by defining LED_BREATHER_GAMMA_EN.
module led_breather
    import led_pkg::*;
#(
    parameter int PWM_BITS = LED_PWM_BITS_DEF,
    parameter int STEP_DIV = LED_STEP_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                blink_in,
    input  logic                enable,
    output logic                WF_LED,
    output logic [PWM_BITS-1:0] level,
    output logic                fading
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0]   STEP_ONE  = 1;
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LEVEL_ONE = 1;
    localparam logic [PWM_BITS-1:0] LEVEL_PRE = LEVEL_MAX - LEVEL_ONE;

    logic                sync1_q, sync2_q, prev_q;
    logic [1:0]          arm_q;
    breath_state_t       state_q;
    logic [PWM_BITS-1:0] level_q;
    logic [STEP_W-1:0]   step_q;
    logic                fading_q;
    logic                led_q;

    logic                armed, rise_edge, fall_edge, step_hit;
    logic [PWM_BITS-1:0] duty_d;
    logic                pwm_raw;

    // Edges are ignored until the synchronizer and previous-value flop hold
    // real samples, so a level already high at reset release starts nothing.
    assign armed     = (arm_q == 2'd3);
    assign rise_edge = armed &  sync2_q & ~prev_q;
    assign fall_edge = armed & ~sync2_q &  prev_q;
    assign step_hit  = (step_q == STEP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            arm_q    <= 2'd0;
            state_q  <= HOLD_LO;
            level_q  <= '0;
            step_q   <= '0;
            fading_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            sync1_q  <= blink_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            if (arm_q != 2'd3) begin
                arm_q <= arm_q + 2'd1;
            end
            fading_q <= (state_q == RISE) || (state_q == FALL);
            led_q    <= enable & pwm_raw;

            if (!enable) begin
                state_q <= HOLD_LO;
                level_q <= '0;
                step_q  <= '0;
            end else if (rise_edge) begin
                state_q <= RISE;
                step_q  <= '0;
            end else if (fall_edge) begin
                state_q <= FALL;
                step_q  <= '0;
            end else begin
                case (state_q)
                    RISE: begin
                        if (level_q == LEVEL_MAX) begin
                            state_q <= HOLD_HI;
                            step_q  <= '0;
                        end else if (step_hit) begin
                            level_q <= level_q + LEVEL_ONE;
                            step_q  <= '0;
                            if (level_q == LEVEL_PRE) begin
                                state_q <= HOLD_HI;
                            end
                        end else begin
                            step_q <= step_q + STEP_ONE;
                        end
                    end
                    FALL: begin
                        if (level_q == '0) begin
                            state_q <= HOLD_LO;
                            step_q  <= '0;
                        end else if (step_hit) begin
                            level_q <= level_q - LEVEL_ONE;
                            step_q  <= '0;
                            if (level_q == LEVEL_ONE) begin
                                state_q <= HOLD_LO;
                            end
                        end else begin
                            step_q <= step_q + STEP_ONE;
                        end
                    end
                    default: begin
                        step_q <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LED_BREATHER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = level_q * level_q;

    always_comb begin
        duty_d = PWM_BITS'(level_sq >> PWM_BITS);
        if (level_q == LEVEL_MAX) begin
            duty_d = LEVEL_MAX;
        end
    end
`else
    always_comb begin
        duty_d = level_q;
    end
`endif

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (duty_d),
        .pwm_out (pwm_raw)
    );

    assign WF_LED = led_q;
    assign level  = level_q;
    assign fading = fading_q;

endmodule

// File: tb/tb_led_breather.sv
// Bench for led_breather with PWM_BITS=4, STEP_DIV=4: level sequence scoreboard
// plus directed checks on timing, PWM duty, enable and reset behaviour.
module tb_led_breather;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       blink_in;
    logic       enable;
    logic       WF_LED;
    logic [3:0] level;
    logic       fading;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    logic [3:0] prev_level = 4'd0;

    always #5 clk = ~clk;

    led_breather #(
        .PWM_BITS (4),
        .STEP_DIV (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .blink_in (blink_in),
        .enable   (enable),
        .WF_LED   (WF_LED),
        .level    (level),
        .fading   (fading)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every change of level pops the next expected value.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_level = level;
        end else if (level !== prev_level) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL level_unexpected: got %0d after %0d with nothing expected", level, prev_level);
            end else begin
                check("level_seq", level, exp_q.pop_front());
            end
            prev_level = level;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_up(input int a, input int b);
        for (int i = a; i <= b; i++) exp_q.push_back(4'(i));
    endtask

    task automatic push_down(input int a, input int b);
        for (int i = a; i >= b; i--) exp_q.push_back(4'(i));
    endtask

    task automatic wait_level(input logic [3:0] v, input int budget, input string name);
        int n;
        n = 0;
        while (level !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, level, v);
    endtask

    task automatic count_high(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (WF_LED === 1'b1) cnt++;
        end
    endtask

    task automatic toggle_blink(input int n);
        repeat (n) begin
            blink_in = ~blink_in;
            cyc(2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_pwm5;
`ifdef LED_BREATHER_GAMMA_EN
        exp_pwm5 = 2;
`else
        exp_pwm5 = 10;
`endif
        rst_n    = 1'b0;
        blink_in = 1'b1;
        enable   = 1'b1;
        cyc(3);
        check("rst_led", WF_LED, 0);
        check("rst_level", level, 0);
        check("rst_fading", fading, 0);

        // High blink level at reset release must not start a ramp.
        rst_n = 1'b1;
        cyc(30);
        check("post_rst_level", level, 0);
        check("post_rst_fading", fading, 0);
        check("post_rst_led", WF_LED, 0);

        blink_in = 1'b0;
        cyc(6);

        // Rise ramp with exact latency checks.
        blink_in = 1'b1;
        push_up(1, 15);
        cyc(3);
        check("fading_before", fading, 0);
        cyc(1);
        check("fading_rise", fading, 1);
        cyc(2);
        check("level_pre_step", level, 0);
        cyc(1);
        check("level_first_step", level, 1);
        wait_level(4'd15, 100, "ramp_top");
        cyc(1);
        check("fading_hold_hi", fading, 0);
        cyc(20);
        count_high(32, n);
        check("led_solid_on", n, 32);

        // Fall to zero.
        blink_in = 1'b0;
        push_down(14, 0);
        wait_level(4'd0, 100, "ramp_bottom");
        cyc(2);
        check("fading_hold_lo", fading, 0);
        cyc(20);
        count_high(32, n);
        check("led_solid_off", n, 0);

        // Reversal at level 6 continues downward without a jump.
        blink_in = 1'b1;
        push_up(1, 6);
        wait_level(4'd6, 60, "rev_at_6");
        blink_in = 1'b0;
        push_down(5, 0);
        wait_level(4'd0, 60, "rev_bottom");
        cyc(2);
        check("rev_fading_done", fading, 0);

        // Hold level 5 by toggling faster than a step, then measure PWM.
        blink_in = 1'b1;
        push_up(1, 5);
        wait_level(4'd5, 60, "pwm_level_5");
        push_up(6, 9);
        fork
            toggle_blink(30);
            begin
                cyc(20);
                count_high(32, n);
            end
        join
        check("pwm_duty_5", n, exp_pwm5);
        check("pwm_level_held", level, 5);

        // Enable drop at level 9.
        wait_level(4'd9, 60, "ramp_to_9");
        enable = 1'b0;
        exp_q.push_back(4'd0);
        cyc(1);
        check("en_level", level, 0);
        check("en_led", WF_LED, 0);
        cyc(5);
        blink_in = 1'b0;
        cyc(5);
        blink_in = 1'b1;
        cyc(10);
        enable = 1'b1;
        cyc(30);
        check("en_no_ramp_level", level, 0);
        check("en_no_ramp_fading", fading, 0);
        check("en_no_ramp_led", WF_LED, 0);

        // Asynchronous reset during FALL.
        blink_in = 1'b0;
        cyc(6);
        blink_in = 1'b1;
        push_up(1, 4);
        wait_level(4'd4, 60, "pre_rst_rise");
        blink_in = 1'b0;
        exp_q.push_back(4'd3);
        wait_level(4'd3, 60, "pre_rst_fall");
        check("pre_rst_fading", fading, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_level", level, 0);
        check("async_rst_fading", fading, 0);
        check("async_rst_led", WF_LED, 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(30);
        check("resume_level", level, 0);
        check("resume_fading", fading, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
